// File: rtl/lvds_tx.sv
// lvds_tx: serializes 32-bit FIFO words into a DDR dibit stream, MSB first, chaining words with no gap.
// Define LVDS_TX_SYNC_INSERT_EN to overwrite dibit 0 with 2'b10 and dibit 8 with 2'b01 (I/Q sync).
module lvds_tx #(
  parameter logic [1:0] IDLE_PATTERN = 2'b00
) (
  input  logic        i_ddr_clk,
  input  logic        i_rst_b,
  input  logic        i_tx_en,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_pull,
  output logic        o_fifo_read_clk,
  output logic [1:0]  o_ddr_data,
  output logic        o_underrun,
  output logic [7:0]  o_underrun_cnt,
  output logic [1:0]  o_debug_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PREFETCH = 2'b01,
    ST_TX       = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        armed_q;
  logic [7:0]  ucnt_q, ucnt_d;
  logic [1:0]  ddr_q, ddr_d;
  logic        pull;
  logic        underrun;

  // armed_q holds off the first pull until one full edge has passed after reset release
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
      ucnt_q  <= '0;
      ddr_q   <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      armed_q <= 1'b1;
      ucnt_q  <= ucnt_d;
      ddr_q   <= ddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ucnt_d   = ucnt_q;
    pull     = 1'b0;
    underrun = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && i_tx_en && !i_fifo_empty) begin
          pull    = 1'b1;
          state_d = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        shift_d = i_fifo_data;
        cnt_d   = 4'd15;
        pend_d  = 1'b0;
        state_d = ST_TX;
      end
      ST_TX: begin
        shift_d = {shift_q[29:0], 2'b00};
        cnt_d   = cnt_q - 4'd1;
        // Fetch the next word one dibit early so it lands right behind the last dibit
        if (cnt_q == 4'd1 && i_tx_en) begin
          if (!i_fifo_empty) begin
            pull   = 1'b1;
            pend_d = 1'b1;
          end else begin
            underrun = 1'b1;
            if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
          end
        end
        if (cnt_q == 4'd0) begin
          if (pend_q) begin
            shift_d = i_fifo_data;
            cnt_d   = 4'd15;
            pend_d  = 1'b0;
          end else begin
            shift_d = '0;
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output dibit is registered from the next-cycle shift contents
  always_comb begin
    ddr_d = IDLE_PATTERN;
    if (state_d == ST_TX) begin
      ddr_d = shift_d[31:30];
`ifdef LVDS_TX_SYNC_INSERT_EN
      if (cnt_d == 4'd15) begin
        ddr_d = 2'b10;
      end else if (cnt_d == 4'd7) begin
        ddr_d = 2'b01;
      end
`endif
    end
  end

  assign o_fifo_pull     = pull;
  assign o_fifo_read_clk = i_ddr_clk;
  assign o_ddr_data      = ddr_q;
  assign o_underrun      = underrun;
  assign o_underrun_cnt  = ucnt_q;
  assign o_debug_state   = state_q;

endmodule
